// File: rtl/bird_io_pkg.sv
// Shared constants for the bird CPU memory/IO bridge: address map, widths
// and status-word bit layout.
package bird_io_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;

    localparam logic [ADDR_W-1:0] RAM_TOP        = 12'hFFB;
    localparam logic [ADDR_W-1:0] RX_STATUS_ADDR = 12'hFFC;
    localparam logic [ADDR_W-1:0] RX_DATA_ADDR   = 12'hFFD;
    localparam logic [ADDR_W-1:0] TX_DATA_ADDR   = 12'hFFE;
    localparam logic [ADDR_W-1:0] TX_STATUS_ADDR = 12'hFFF;

    localparam int ST_NONEMPTY_BIT = 0;
    localparam int ST_FULL_BIT     = 1;
    localparam int ST_OVF_BIT      = 2;
    localparam int ST_COUNT_LSB    = 4;

    // RX status has no overflow flag; callers pass 1'b0 for it.
    function automatic logic [DATA_W-1:0] status_word(
        input logic [CNT_W-1:0] count,
        input logic             ovf,
        input logic             full,
        input logic             nonempty
    );
        logic [DATA_W-1:0] w;
        w                                = '0;
        w[ST_COUNT_LSB +: CNT_W]         = count;
        w[ST_OVF_BIT]                    = ovf;
        w[ST_FULL_BIT]                   = full;
        w[ST_NONEMPTY_BIT]               = nonempty;
        return w;
    endfunction

endpackage

// File: rtl/bird_fifo.sv
// Power-of-two synchronous FIFO; push is refused when full, pop when empty.
// Head reads as zero while empty so storage needs no reset.
module bird_fifo
    import bird_io_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_head,
    output logic              o_full,
    output logic              o_empty,
    output logic [CNT_W-1:0]  o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_rd_ptr;
    logic [AW-1:0]     r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/bird_io_bridge.sv
// Bird CPU bus to 4K RAM plus four memory-mapped FIFO registers.
// Reads are combinational; all FIFO and flag state changes on the clock edge.
module bird_io_bridge
    import bird_io_pkg::*;
#(
    parameter int RX_DEPTH = 4,
    parameter int TX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_address,
    input  logic [15:0] cpu_data_out,
    input  logic        cpu_memwt,
    output logic [15:0] cpu_data_in,
    output logic [11:0] mem_address,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    input  logic        rx_valid,
    input  logic [15:0] rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [15:0] tx_data,
    input  logic        tx_ready
);

    logic [ADDR_W-1:0] w_addr;
    logic              w_unused;
    logic              w_rx_pop;
    logic              w_tx_wr;
    logic              w_tx_stat_wr;
    logic [DATA_W-1:0] w_rx_head;
    logic [DATA_W-1:0] w_tx_head;
    logic              w_rx_full;
    logic              w_rx_empty;
    logic              w_tx_full;
    logic              w_tx_empty;
    logic [CNT_W-1:0]  w_rx_count;
    logic [CNT_W-1:0]  w_tx_count;
    logic [DATA_W-1:0] w_rdata;
    logic              r_tx_ovf;

    assign w_addr       = cpu_address[ADDR_W-1:0];
    assign w_unused     = ^cpu_address[15:ADDR_W];
    assign mem_address  = w_addr;
    assign mem_wdata    = cpu_data_out;
    assign mem_we       = cpu_memwt & (w_addr <= RAM_TOP);

    // Any non-write cycle on RX_DATA is a read, so instruction fetches there would pop too.
    assign w_rx_pop     = ~cpu_memwt & (w_addr == RX_DATA_ADDR);
    assign w_tx_wr      = cpu_memwt & (w_addr == TX_DATA_ADDR);
    assign w_tx_stat_wr = cpu_memwt & (w_addr == TX_STATUS_ADDR);

    assign rx_ready     = ~w_rx_full;
    assign tx_valid     = ~w_tx_empty;
    assign tx_data      = w_tx_head;

    bird_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (rx_valid),
        .i_pop   (w_rx_pop),
        .i_data  (rx_data),
        .o_head  (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (w_rx_count)
    );

    bird_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_tx_wr),
        .i_pop   (tx_ready),
        .i_data  (cpu_data_out),
        .o_head  (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (w_tx_count)
    );

    // Overflow is judged on the pre-edge full flag, so a same-cycle drain does not save the word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_ovf <= 1'b0;
        end else if (w_tx_wr && w_tx_full) begin
            r_tx_ovf <= 1'b1;
        end else if (w_tx_stat_wr) begin
            r_tx_ovf <= 1'b0;
        end
    end

    always_comb begin
        w_rdata = mem_rdata;
        case (w_addr)
            RX_STATUS_ADDR: w_rdata = status_word(w_rx_count, 1'b0, w_rx_full, ~w_rx_empty);
            RX_DATA_ADDR:   w_rdata = w_rx_head;
            TX_DATA_ADDR:   w_rdata = '0;
            TX_STATUS_ADDR: w_rdata = status_word(w_tx_count, r_tx_ovf, w_tx_full, ~w_tx_empty);
            default:        w_rdata = mem_rdata;
        endcase
    end

    assign cpu_data_in = w_rdata;

endmodule

// File: tb/tb_bird_io_bridge.sv
// Directed and randomized bench for bird_io_bridge with a queue-based model.
module tb_bird_io_bridge;

    localparam int RXD = 4;
    localparam int TXD = 4;

    logic        clk;
    logic        rst;
    logic [15:0] cpu_address;
    logic [15:0] cpu_data_out;
    logic        cpu_memwt;
    logic [15:0] cpu_data_in;
    logic [11:0] mem_address;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic        rx_valid;
    logic [15:0] rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [15:0] tx_data;
    logic        tx_ready;

    int checks;
    int failures;

    bird_io_bridge #(.RX_DEPTH(RXD), .TX_DEPTH(TXD)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_address  (cpu_address),
        .cpu_data_out (cpu_data_out),
        .cpu_memwt    (cpu_memwt),
        .cpu_data_in  (cpu_data_in),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [15:0] addr, input string tag, input logic [15:0] exp);
        cpu_memwt   = 1'b0;
        cpu_address = addr;
        #1;
        chk(tag, cpu_data_in, exp);
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] data);
        cpu_memwt    = 1'b1;
        cpu_address  = addr;
        cpu_data_out = data;
        tick();
        cpu_memwt    = 1'b0;
        cpu_address  = 16'h0000;
    endtask

    logic [15:0] rxq[$];
    logic [15:0] txq[$];
    logic        ovf;
    logic [11:0] a;
    logic [15:0] exp_rd;
    int          rxn;
    int          txn;
    int          sel;

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1;
        cpu_address = 16'h0000; cpu_data_out = 16'h0000; cpu_memwt = 1'b0;
        mem_rdata = 16'h0000; rx_valid = 1'b0; rx_data = 16'h0000; tx_ready = 1'b0;
        tick(); tick();

        // word offered while reset is held must be ignored
        rx_valid = 1'b1; rx_data = 16'hDEAD;
        tick();
        rx_valid = 1'b0; rst = 1'b0;
        rd(16'h0FFC, "reset_rx_status", 16'h0000);
        rd(16'h0FFF, "reset_tx_status", 16'h0000);
        chk("reset_rx_ready", {15'h0, rx_ready}, 16'h0001);
        chk("reset_tx_valid", {15'h0, tx_valid}, 16'h0000);
        chk("reset_tx_data", tx_data, 16'h0000);

        // RAM write and read, upper address bits ignored
        cpu_memwt = 1'b1; cpu_address = 16'h0010; cpu_data_out = 16'h5A5A;
        #1;
        chk("ram_we", {15'h0, mem_we}, 16'h0001);
        chk("ram_addr", {4'h0, mem_address}, 16'h0010);
        chk("ram_wdata", mem_wdata, 16'h5A5A);
        tick();
        cpu_memwt = 1'b1; cpu_address = 16'h0FFE; cpu_data_out = 16'h1111;
        #1;
        chk("io_we_low", {15'h0, mem_we}, 16'h0000);
        cpu_memwt = 1'b0; cpu_address = 16'h0FFE;
        #1;
        chk("tx_data_read_zero", cpu_data_in, 16'h0000);
        rd(16'h7FFC, "upper_bits_rx_status", 16'h0000);
        chk("read_no_we", {15'h0, mem_we}, 16'h0000);
        mem_rdata = 16'hBEEF;
        rd(16'hA123, "ram_read", 16'hBEEF);

        // RX ordering and empty read
        cpu_address = 16'h0000;
        rx_valid = 1'b1; rx_data = 16'h1234; tick();
        rx_data = 16'hABCD; tick();
        rx_valid = 1'b0;
        rd(16'h0FFC, "rx_status_two", 16'h0021);
        rd(16'h0FFD, "rx_pop_first", 16'h1234);
        tick();
        rd(16'h0FFD, "rx_pop_second", 16'hABCD);
        tick();
        rd(16'h0FFD, "rx_empty_read", 16'h0000);
        tick();
        rd(16'h0FFC, "rx_status_empty", 16'h0000);

        // RX full and backpressure
        cpu_address = 16'h0000;
        rx_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            rx_data = 16'(16'h0100 + i);
            tick();
        end
        chk("rx_full_ready", {15'h0, rx_ready}, 16'h0000);
        rd(16'h0FFC, "rx_status_full", 16'h0043);
        rx_data = 16'h0105;
        tick();
        rd(16'h0FFC, "rx_full_held", 16'h0043);
        rd(16'h0FFD, "rx_full_pop_head", 16'h0101);
        chk("rx_ready_during_pop", {15'h0, rx_ready}, 16'h0000);
        tick();
        cpu_address = 16'h0000;
        #1;
        chk("rx_ready_after_pop", {15'h0, rx_ready}, 16'h0001);
        tick();
        rx_valid = 1'b0;
        rd(16'h0FFC, "rx_refilled", 16'h0043);
        for (int i = 2; i <= 5; i++) begin
            rd(16'h0FFD, "rx_drain", 16'(16'h0100 + i));
            tick();
        end
        rd(16'h0FFC, "rx_drained", 16'h0000);

        // TX overflow and drain
        tx_ready = 1'b0;
        wr(16'h0FFE, 16'h00F0);
        #1;
        chk("tx_push_visible", tx_data, 16'h00F0);
        chk("tx_valid_after_push", {15'h0, tx_valid}, 16'h0001);
        for (int i = 1; i <= 4; i++) wr(16'h0FFE, 16'(16'h00F0 + i));
        rd(16'h0FFF, "tx_status_ovf", 16'h0047);
        wr(16'h0FFF, 16'h0000);
        rd(16'h0FFF, "tx_status_cleared", 16'h0043);
        cpu_address = 16'h0000;
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("tx_drain_valid", {15'h0, tx_valid}, 16'h0001);
            chk("tx_drain_data", tx_data, 16'(16'h00F0 + i));
            tick();
        end
        chk("tx_empty_valid", {15'h0, tx_valid}, 16'h0000);
        chk("tx_empty_data", tx_data, 16'h0000);
        tx_ready = 1'b0;

        // simultaneous RX push and pop
        cpu_address = 16'h0000;
        rx_valid = 1'b1; rx_data = 16'h0001; tick();
        rx_data = 16'h0002;
        rd(16'h0FFD, "rx_simul_head", 16'h0001);
        tick();
        rx_valid = 1'b0;
        rd(16'h0FFC, "rx_simul_count", 16'h0011);
        rd(16'h0FFD, "rx_simul_next", 16'h0002);
        tick();
        rd(16'h0FFC, "rx_simul_empty", 16'h0000);

        // reset mid-operation
        cpu_address = 16'h0000;
        rx_valid = 1'b1; rx_data = 16'h0AAA; tick(); tick();
        rx_valid = 1'b0;
        for (int i = 0; i < 5; i++) wr(16'h0FFE, 16'(16'h0300 + i));
        rd(16'h0FFF, "pre_reset_tx", 16'h0047);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd(16'h0FFC, "mid_reset_rx_status", 16'h0000);
        rd(16'h0FFF, "mid_reset_tx_status", 16'h0000);
        chk("mid_reset_rx_ready", {15'h0, rx_ready}, 16'h0001);
        chk("mid_reset_tx_valid", {15'h0, tx_valid}, 16'h0000);

        // randomized traffic against the queue model
        rxq.delete(); txq.delete(); ovf = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            sel = int'($urandom_range(0, 7));
            a = (sel < 4) ? 12'hFFC + 12'(sel) : 12'($urandom_range(0, 12'hFFB));
            cpu_address  = {4'($urandom), a};
            cpu_memwt    = ($urandom_range(0, 2) == 0);
            cpu_data_out = 16'($urandom);
            rx_valid     = 1'($urandom_range(0, 1));
            rx_data      = 16'($urandom);
            tx_ready     = 1'($urandom_range(0, 1));
            mem_rdata    = 16'($urandom);
            #1;
            rxn = rxq.size();
            txn = txq.size();
            if (a == 12'hFFC)      exp_rd = {8'h00, 4'(rxn), 2'b00, rxn == RXD, rxn != 0};
            else if (a == 12'hFFD) exp_rd = (rxn != 0) ? rxq[0] : 16'h0000;
            else if (a == 12'hFFE) exp_rd = 16'h0000;
            else if (a == 12'hFFF) exp_rd = {8'h00, 4'(txn), 1'b0, ovf, txn == TXD, txn != 0};
            else                   exp_rd = mem_rdata;
            if (!cpu_memwt) chk("rand_rdata", cpu_data_in, exp_rd);
            chk("rand_mem_we", {15'h0, mem_we}, {15'h0, cpu_memwt && (a <= 12'hFFB)});
            chk("rand_mem_addr", {4'h0, mem_address}, {4'h0, a});
            chk("rand_rx_ready", {15'h0, rx_ready}, {15'h0, rxn < RXD});
            chk("rand_tx_valid", {15'h0, tx_valid}, {15'h0, txn != 0});
            chk("rand_tx_data", tx_data, (txn != 0) ? txq[0] : 16'h0000);
            if (!cpu_memwt && a == 12'hFFD && rxn > 0) void'(rxq.pop_front());
            if (rx_valid && rxn < RXD) rxq.push_back(rx_data);
            if (tx_ready && txn > 0) void'(txq.pop_front());
            if (cpu_memwt && a == 12'hFFE) begin
                if (txn < TXD) txq.push_back(cpu_data_out);
                else ovf = 1'b1;
            end
            if (cpu_memwt && a == 12'hFFF) ovf = 1'b0;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bird_io_bridge.md
# bird_io_bridge

Memory/IO bridge sitting directly downstream of the bird CPU bus (address, data_out, memwt) and driving its data_in. Decodes the 12-bit word address space into the external 4K RAM and four memory-mapped IO registers backed by a receive FIFO (peripheral → CPU) and a transmit FIFO (CPU → peripheral). Reads are combinational because the CPU samples data_in in the same cycle it drives address; all FIFO and flag updates happen on the clock edge.

## Interface
- RX_DEPTH, 4, receive FIFO depth; power of two, 2..8
- TX_DEPTH, 4, transmit FIFO depth; power of two, 2..8

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_address  in  16  CPU address; only [11:0] decoded, [15:12] ignored
- cpu_data_out  in  16  CPU write data
- cpu_memwt  in  1  CPU write strobe
- cpu_data_in  out  16  read data to CPU
- mem_address  out  12  RAM address (= cpu_address[11:0])
- mem_wdata  out  16  RAM write data (= cpu_data_out)
- mem_we  out  1  RAM write enable
- mem_rdata  in  16  RAM asynchronous read data
- rx_valid  in  1  peripheral offers rx_data
- rx_data  in  16  inbound word
- rx_ready  out  1  RX FIFO not full
- tx_valid  out  1  TX FIFO not empty
- tx_data  out  16  TX FIFO head
- tx_ready  in  1  peripheral accepts tx_data

## Operation
- Map on a = cpu_address[11:0]: 0x000–0xFFB RAM; 0xFFC RX_STATUS (R); 0xFFD RX_DATA (R, pops); 0xFFE TX_DATA (W, pushes); 0xFFF TX_STATUS (R; any write clears overflow).
- RX_STATUS = {8'h0, count[3:0], 2'b0, full, nonempty}. TX_STATUS = {8'h0, count[3:0], 1'b0, overflow, full, nonempty}.
- mem_we = cpu_memwt & (a ≤ 0xFFB). Writes to 0xFFC/0xFFD ignored. Reads of 0xFFE return 0x0000.
- Read cycle = any cycle with cpu_memwt=0. Every clock edge with a=0xFFD, cpu_memwt=0, RX nonempty pops one word; cpu_data_in shows the head that same cycle. Empty RX_DATA read returns 0x0000, no pop. Software rule: no code or stack at 0xFFC–0xFFF (fetch would pop).
- RX push: rx_valid & rx_ready at edge. rx_ready = !full, independent of a simultaneous pop.
- TX push: cpu_memwt & a=0xFFE. If full: word dropped, overflow ← 1 (sticky), even if tx_ready pops the same cycle. TX pop: tx_valid & tx_ready.
- Simultaneous push and pop on non-full, non-empty FIFO: count unchanged, order preserved.
- Pointers wrap modulo depth; count width 4 bits.

## Timing
- Read path combinational, zero latency: cpu_data_in valid while cpu_address stable.
- Push/pop/overflow/clear take effect at the rising edge; status reads in the next cycle reflect them.
- TX word pushed at edge N is on tx_data with tx_valid=1 from edge N (after edge N).
- Reset values: both FIFOs empty, counts 0, overflow 0, rx_ready=1, tx_valid=0, tx_data=0x0000. Reset mid-transfer discards all buffered data; rx_data offered during reset is not accepted.

## Structure
- Package bird_io_pkg: address constants RX_STATUS_ADDR, RX_DATA_ADDR, TX_DATA_ADDR, TX_STATUS_ADDR, RAM_TOP=0xFFB, status bit positions.
- Sub-module bird_fifo (parameter DEPTH, 16-bit data, push/pop/full/empty/count, async active-high rst), instantiated twice; bridge top holds decode, read mux, overflow flag.

## Test plan
- RAM: write 0x5A5A to 0x010 → mem_we=1, mem_address=0x010, mem_wdata=0x5A5A; read address 0x7FFC → RX_STATUS (upper bits ignored), mem_we=0.
- RX order: push 0x1234, 0xABCD; read 0xFFC → 0x0021; read 0xFFD → 0x1234, then 0xABCD; then RX_STATUS → 0x0000, RX_DATA → 0x0000.
- RX full: 4 pushes → rx_ready=0, RX_STATUS 0x0043; 5th rx_valid held until one pop, then accepted next edge.
- TX overflow: tx_ready=0, write 0x00F0..0x00F4 to 0xFFE → TX_STATUS 0x0047; write 0xFFF → 0x0043; tx_ready=1 → 0x00F0..0x00F3 out one per cycle, tx_valid drops.
- Simultaneous: RX count 1, push 0x0002 while popping 0x0001 → read returns 0x0001, count stays 1, next read 0x0002.
- Reset mid-operation: RX count 2, TX overflow set, assert rst for one cycle → RX_STATUS 0x0000, TX_STATUS 0x0000, rx_ready=1, tx_valid=0.
